// File: rtl/adder_8bit_pkg.sv
// Shared types for the 8-bit ripple-carry adder: result bundle and its reset value.
package adder_8bit_pkg;

  localparam int ADDER_WIDTH = 8;

  typedef struct packed {
    logic                   carry_out;
    logic                   overflow;
    logic [ADDER_WIDTH-1:0] sum;
  } add_result_t;

  localparam add_result_t RESULT_RESET = '{carry_out: 1'b0, overflow: 1'b0, sum: '0};

endpackage

// File: rtl/adder_8bit_full_adder.sv
// Single-bit full adder cell used as one stage of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_8bit.sv
// 8-bit ripple-carry adder with combinational sum/carry/overflow and a
// registered copy of all three, cleared asynchronously by rst_n.
module adder_8bit
  import adder_8bit_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_out_q,
  output logic             overflow_q
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the final carry out.
  logic [WIDTH:0] carry;
  add_result_t    result_next;
  add_result_t    result_reg;

  assign carry[0] = carry_in;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
      full_adder u_fa (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (carry[gi]),
        .s    (sum[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  assign carry_out = carry[WIDTH];
  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign overflow  = carry[WIDTH-1] ^ carry[WIDTH];

  always_comb begin
    result_next           = RESULT_RESET;
    result_next.sum       = sum;
    result_next.carry_out = carry_out;
    result_next.overflow  = overflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= RESULT_RESET;
    end else begin
      result_reg <= result_next;
    end
  end

  assign sum_q       = result_reg.sum;
  assign carry_out_q = result_reg.carry_out;
  assign overflow_q  = result_reg.overflow;

endmodule

// File: tb/tb_adder_8bit.sv
// Directed self-checking bench for adder_8bit: combinational vectors,
// wrap/overflow corners, and the asynchronously reset registered copy.
module tb_adder_8bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       carry_in;
  logic [7:0] sum;
  logic       carry_out;
  logic       overflow;
  logic [7:0] sum_q;
  logic       carry_out_q;
  logic       overflow_q;

  int checks   = 0;
  int failures = 0;

  adder_8bit #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .carry_in    (carry_in),
    .sum         (sum),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .sum_q       (sum_q),
    .carry_out_q (carry_out_q),
    .overflow_q  (overflow_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag, input logic [7:0] es, input logic ec, input logic eo);
    check({tag, ".sum"}, sum, es);
    check({tag, ".carry_out"}, {7'd0, carry_out}, {7'd0, ec});
    check({tag, ".overflow"}, {7'd0, overflow}, {7'd0, eo});
    $display("comb %s a=%02h b=%02h cin=%0d -> sum=%02h co=%0d ov=%0d",
             tag, a, b, carry_in, sum, carry_out, overflow);
  endtask

  task automatic check_reg(input string tag, input logic [7:0] es, input logic ec, input logic eo);
    check({tag, ".sum_q"}, sum_q, es);
    check({tag, ".carry_out_q"}, {7'd0, carry_out_q}, {7'd0, ec});
    check({tag, ".overflow_q"}, {7'd0, overflow_q}, {7'd0, eo});
    $display("reg  %s sum_q=%02h co_q=%0d ov_q=%0d", tag, sum_q, carry_out_q, overflow_q);
  endtask

  initial begin
    rst_n    = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    carry_in = 1'b0;
    #1;
    // Reset before any clock edge: registered outputs already cleared.
    check_reg("reset_no_clk", 8'h00, 1'b0, 1'b0);
    check_comb("zero", 8'h00, 1'b0, 1'b0);

    a = 8'hFF; b = 8'h01; carry_in = 1'b0; #1;
    check_comb("ff_plus_1", 8'h00, 1'b1, 1'b0);

    a = 8'h80; b = 8'h80; carry_in = 1'b0; #1;
    check_comb("neg_overflow", 8'h00, 1'b1, 1'b1);

    a = 8'h7F; b = 8'h7F; carry_in = 1'b1; #1;
    check_comb("pos_overflow", 8'hFF, 1'b0, 1'b1);

    a = 8'hFF; b = 8'hFF; carry_in = 1'b1; #1;
    check_comb("max_case", 8'hFF, 1'b1, 1'b0);

    a = 8'h55; b = 8'hAA; carry_in = 1'b0; #1;
    check_comb("alt_bits", 8'hFF, 1'b0, 1'b0);

    a = 8'h01; b = 8'h01; carry_in = 1'b1; #1;
    check_comb("cin_counts", 8'h03, 1'b0, 1'b0);

    // Back-to-back input changes, no clock involvement.
    a = 8'hC8; b = 8'h37; carry_in = 1'b1; #1;
    check_comb("c8_37_1", 8'h00, 1'b1, 1'b0);
    a = 8'h00; b = 8'hFF; carry_in = 1'b1; #1;
    check_comb("00_ff_1", 8'h00, 1'b1, 1'b0);

    // Still in reset after clock edges: registers hold zero, comb path live.
    @(posedge clk); #1;
    check_reg("held_in_reset", 8'h00, 1'b0, 1'b0);

    // Release away from the edge, load 0x7F+0x7F+1.
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'h7F; b = 8'h7F; carry_in = 1'b1; #1;
    check_reg("after_release", 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_reg("first_edge", 8'hFF, 1'b0, 1'b1);

    a = 8'hFF; b = 8'h01; carry_in = 1'b0;
    @(posedge clk); #1;
    check_reg("second_edge", 8'h00, 1'b1, 1'b0);

    a = 8'h7F; b = 8'h7F; carry_in = 1'b1;
    @(posedge clk); #1;
    check_reg("third_edge", 8'hFF, 1'b0, 1'b1);

    // Asynchronous reset between edges clears registers but not comb outputs.
    #2;
    rst_n = 1'b0; #1;
    check_reg("async_reset", 8'h00, 1'b0, 1'b0);
    check_comb("comb_during_reset", 8'hFF, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_8bit.md
ADDER_8BIT -- requirements
Module: adder_8bit

Interface
REQ-001 Parameter WIDTH, default 8, operand/sum width; SHALL be fixed at 8 for this block.
REQ-002 clk  input  1  rising-edge clock for the registered result copy.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 a  input  8  unsigned/two's-complement addend A.
REQ-005 b  input  8  addend B.
REQ-006 carry_in  input  1  carry into bit 0.
REQ-007 sum  output  8  combinational low 8 bits of a+b+carry_in.
REQ-008 carry_out  output  1  combinational carry out of bit 7.
REQ-009 overflow  output  1  combinational signed overflow of the two's-complement add.
REQ-010 sum_q  output  8  registered copy of sum.
REQ-011 carry_out_q  output  1  registered copy of carry_out.
REQ-012 overflow_q  output  1  registered copy of overflow.

Function
REQ-013 {carry_out,sum} SHALL equal a+b+carry_in as a 9-bit unsigned result, zero latency, no clock dependency.
REQ-014 sum/carry_out SHALL settle within the same delta/timestep as any input change; no latch, no state.
REQ-015 overflow SHALL be 1 iff a[7]==b[7] and sum[7]!=a[7] (equivalently carry into bit 7 XOR carry_out).
REQ-016 Wrap-around: results of 256..511 SHALL wrap sum modulo 256 with carry_out=1; max case 255+255+1 -> sum=0xFF, carry_out=1.
REQ-017 sum_q, carry_out_q, overflow_q SHALL capture sum, carry_out, overflow on every rising clk edge while rst_n=1 (1-cycle latency, no enable).
REQ-018 Combinational outputs SHALL remain correct regardless of clk activity or rst_n level.
REQ-019 carry_in SHALL be treated as a full third operand bit, not masked or gated.

Reset
REQ-020 rst_n=0 SHALL immediately (asynchronously) force sum_q=0x00, carry_out_q=0, overflow_q=0.
REQ-021 Registered outputs SHALL hold reset values until the first rising clk edge after rst_n deasserts.
REQ-022 Reset asserted mid-operation SHALL not affect sum, carry_out, overflow.

Structure
REQ-023 Datapath SHALL be a ripple-carry chain of 8 instances of sub-module full_adder (inputs a, b, cin; outputs s, cout).
REQ-024 Carry into bit 7 SHALL be exposed internally for the overflow computation.
REQ-025 No shared package is required; WIDTH stays a local module parameter.
REQ-026 Only the three registered outputs SHALL be sequential; all else combinational.

Verification
REQ-027 a=0x00, b=0x00, cin=0 -> sum=0x00, carry_out=0, overflow=0.
REQ-028 a=0xFF, b=0x01, cin=0 -> sum=0x00, carry_out=1, overflow=0.
REQ-029 a=0x80, b=0x80, cin=0 -> sum=0x00, carry_out=1, overflow=1.
REQ-030 a=0x7F, b=0x7F, cin=1 -> sum=0xFF, carry_out=0, overflow=1.
REQ-031 a=0xC8, b=0x37, cin=1 and a=0x00, b=0xFF, cin=1 -> sum=0x00, carry_out=1, overflow=0 each; inputs changed back-to-back with zero delay, comb outputs checked immediately.
REQ-032 Registered path: rst_n=0 -> sum_q=0x00 without clk; release, apply 0x7F+0x7F+1, one rising edge -> sum_q=0xFF, carry_out_q=0, overflow_q=1; assert rst_n=0 between edges -> sum_q=0x00 immediately.
